// File: rtl/mips_ctrl_pkg.sv
// Shared constants and types for the multicycle MIPS-subset controller.
// Opcodes, function codes, ALU select codes, FSM states and decode record.
package mips_ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WRITEBACK, S_HALT
  } state_e;

  // IC_ALU covers every register-writing ALU op (legal R-type and addi).
  typedef enum logic [2:0] {
    IC_ALU, IC_LW, IC_SW, IC_BEQ, IC_J, IC_HALT, IC_ILLEGAL
  } iclass_e;

  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       ovf_chk;
    logic [3:0] alu_ctrl;
    iclass_e    iclass;
    logic       legal;
  } dec_t;

  function automatic logic [31:0] br_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Pure combinational instruction decode: opcode/funct to static datapath
// controls, ALU select, instruction class and legality.
module ctrl_decode
  import mips_ctrl_pkg::*;
(
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  output dec_t       dec
);

  always_comb begin
    dec = '{reg_dst: 1'b0, alu_src: 1'b0, mem_to_reg: 1'b1, ovf_chk: 1'b0,
            alu_ctrl: ALU_ADD, iclass: IC_ILLEGAL, legal: 1'b0};
    case (opcode)
      OP_RTYPE: begin
        dec.reg_dst = 1'b1;
        dec.iclass  = IC_ALU;
        dec.legal   = 1'b1;
        case (funct)
          FN_ADD: begin dec.alu_ctrl = ALU_ADD; dec.ovf_chk = 1'b1; end
          FN_SUB: begin dec.alu_ctrl = ALU_SUB; dec.ovf_chk = 1'b1; end
          FN_AND: dec.alu_ctrl = ALU_AND;
          FN_OR:  dec.alu_ctrl = ALU_OR;
          FN_SLT: dec.alu_ctrl = ALU_SLT;
          default: begin
            dec.iclass = IC_ILLEGAL;
            dec.legal  = 1'b0;
          end
        endcase
      end
      OP_ADDI: begin
        dec.alu_src = 1'b1;
        dec.ovf_chk = 1'b1;
        dec.iclass  = IC_ALU;
        dec.legal   = 1'b1;
      end
      OP_LW: begin
        dec.alu_src    = 1'b1;
        dec.mem_to_reg = 1'b0;
        dec.iclass     = IC_LW;
        dec.legal      = 1'b1;
      end
      OP_SW: begin
        dec.alu_src = 1'b1;
        dec.iclass  = IC_SW;
        dec.legal   = 1'b1;
      end
      OP_BEQ: begin
        dec.alu_ctrl = ALU_SUB;
        dec.iclass   = IC_BEQ;
        dec.legal    = 1'b1;
      end
      OP_J: begin
        dec.iclass = IC_J;
        dec.legal  = 1'b1;
      end
      OP_HALT: begin
        dec.iclass = IC_HALT;
        dec.legal  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle controller: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencing,
// PC and IR ownership, trap/illegal pulses and retired-instruction counter.
module multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  input  logic        imem_ready,
  input  logic        zero,
  input  logic        overflow,
  output logic [25:0] Instruction,
  output logic        RegDst,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        MemToReg,
  output logic        ALUSrc,
  output logic        RegWrite,
  output logic [3:0]  ALUControl_Signal,
  output logic        ovf_trap,
  output logic        illegal,
  output logic        halted,
  output logic [31:0] retired_cnt
);

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic [31:0] cnt_q, cnt_d;
  logic        ovf_trap_q, ovf_trap_d;
  logic        illegal_q, illegal_d;
  logic        retire;
  dec_t        dec;

  ctrl_decode u_dec (
    .opcode (ir_q[31:26]),
    .funct  (ir_q[5:0]),
    .dec    (dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_FETCH;
      pc_q       <= RESET_PC;
      ir_q       <= '0;
      cnt_q      <= '0;
      ovf_trap_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      ir_q       <= ir_d;
      cnt_q      <= cnt_d;
      ovf_trap_q <= ovf_trap_d;
      illegal_q  <= illegal_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ir_d       = ir_q;
    retire     = 1'b0;
    ovf_trap_d = 1'b0;
    illegal_d  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (imem_ready) begin
          ir_d    = imem_data;
          pc_d    = pc_q + 32'd4;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        if (!dec.legal) begin
          illegal_d = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end else begin
          case (dec.iclass)
            IC_J: begin
              pc_d    = {pc_q[31:28], ir_q[25:0], 2'b00};
              retire  = 1'b1;
              state_d = S_FETCH;
            end
            IC_HALT: begin
              // PC parks on the halt instruction itself, not the one after.
              pc_d    = pc_q - 32'd4;
              retire  = 1'b1;
              state_d = S_HALT;
            end
            default: state_d = S_EXECUTE;
          endcase
        end
      end
      S_EXECUTE: begin
        case (dec.iclass)
          IC_BEQ: begin
            if (zero) pc_d = pc_q + br_offset(ir_q[15:0]);
            retire  = 1'b1;
            state_d = S_FETCH;
          end
          IC_LW, IC_SW: state_d = S_MEM;
          default: begin
            if (dec.ovf_chk && overflow) begin
              ovf_trap_d = 1'b1;
              retire     = 1'b1;
              state_d    = S_FETCH;
            end else begin
              state_d = S_WRITEBACK;
            end
          end
        endcase
      end
      S_MEM: begin
        if (dec.iclass == IC_SW) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end else begin
          state_d = S_WRITEBACK;
        end
      end
      S_WRITEBACK: begin
        retire  = 1'b1;
        state_d = S_FETCH;
      end
      S_HALT:  ;
      default: state_d = S_FETCH;
    endcase
    cnt_d = cnt_q + {31'd0, retire};
  end

  // Write enables drop immediately with rst_n, even mid-MEM/WRITEBACK.
  always_comb begin
    MemRead  = 1'b0;
    MemWrite = 1'b0;
    RegWrite = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_MEM: begin
          MemRead  = (dec.iclass == IC_LW);
          MemWrite = (dec.iclass == IC_SW);
        end
        S_WRITEBACK: begin
          RegWrite = 1'b1;
          MemRead  = (dec.iclass == IC_LW);
        end
        default: ;
      endcase
    end
  end

  assign imem_addr         = pc_q;
  assign Instruction       = ir_q[25:0];
  assign RegDst            = dec.reg_dst;
  assign ALUSrc            = dec.alu_src;
  assign MemToReg          = dec.mem_to_reg;
  assign ALUControl_Signal = dec.alu_ctrl;
  assign ovf_trap          = ovf_trap_q;
  assign illegal           = illegal_q;
  assign halted            = (state_q == S_HALT);
  assign retired_cnt       = cnt_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: directed vector table, hand-written corner
// sequences, then random instructions against a per-instruction model.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] imem_addr;
  logic [31:0] imem_data = '0;
  logic        imem_ready = 1'b0, zero = 1'b0, overflow = 1'b0;
  logic [25:0] Instruction;
  logic        RegDst, MemRead, MemWrite, MemToReg, ALUSrc, RegWrite;
  logic [3:0]  ALUControl_Signal;
  logic        ovf_trap, illegal, halted;
  logic [31:0] retired_cnt;
  int          total = 0, bad = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
    .imem_ready(imem_ready), .zero(zero), .overflow(overflow),
    .Instruction(Instruction), .RegDst(RegDst), .MemRead(MemRead),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .ALUSrc(ALUSrc),
    .RegWrite(RegWrite), .ALUControl_Signal(ALUControl_Signal),
    .ovf_trap(ovf_trap), .illegal(illegal), .halted(halted),
    .retired_cnt(retired_cnt)
  );

  // One instruction's observable outcome; mr/mw/rw bit c = enable in cycle c.
  typedef struct {
    int          cycles;
    logic [7:0]  mr, mw, rw;
    logic        rd, as, mt;
    logic [3:0]  alu;
    logic [31:0] pc;
    logic        trap, ill, halt;
    logic        cs, ca;
  } res_t;

  typedef struct {
    logic [31:0] word;
    logic        z, o;
    res_t        exp;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst_n = 1'b0;
    imem_ready = 1'b0;
    tick;
    tick;
    rst_n = 1'b1;
  endtask

  function automatic res_t mk(input int cy, input logic [7:0] mr, mw, rw,
                              input logic rd, as, mt, input logic [3:0] alu,
                              input logic [31:0] pc, input logic trap, ill, halt, cs, ca);
    res_t r;
    r.cycles = cy; r.mr = mr; r.mw = mw; r.rw = rw;
    r.rd = rd; r.as = as; r.mt = mt; r.alu = alu; r.pc = pc;
    r.trap = trap; r.ill = ill; r.halt = halt; r.cs = cs; r.ca = ca;
    return r;
  endfunction

  task automatic add_vec(input logic [31:0] w, input logic z, o, input res_t e);
    vec_t v;
    v.word = w; v.z = z; v.o = o; v.exp = e;
    tv.push_back(v);
  endtask

  // Instruction-level reference: cycles, enable timeline and next PC.
  function automatic res_t model(input logic [31:0] w, input logic [31:0] pc,
                                 input logic z, input logic o);
    res_t        e;
    logic [31:0] npc;
    logic        arith, legal;
    npc = pc + 32'd4;
    e = mk(0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 4'b0010, npc,
           1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    arith = 1'b0;
    legal = 1'b1;
    case (w[31:26])
      6'h00: begin
        e.rd = 1'b1;
        case (w[5:0])
          6'h20: arith = 1'b1;
          6'h22: begin e.alu = 4'b0110; arith = 1'b1; end
          6'h24: e.alu = 4'b0000;
          6'h25: e.alu = 4'b0001;
          6'h2A: e.alu = 4'b0111;
          default: legal = 1'b0;
        endcase
        if (!legal) begin
          e.cycles = 2; e.ill = 1'b1; e.cs = 1'b0; e.ca = 1'b0;
        end else if (arith && o) begin
          e.cycles = 3; e.trap = 1'b1;
        end else begin
          e.cycles = 4; e.rw = 8'h08;
        end
      end
      6'h08: begin
        e.as = 1'b1;
        if (o) begin e.cycles = 3; e.trap = 1'b1; end
        else   begin e.cycles = 4; e.rw = 8'h08; end
      end
      6'h23: begin e.as = 1'b1; e.mt = 1'b0; e.cycles = 5; e.mr = 8'h18; e.rw = 8'h10; end
      6'h2B: begin e.as = 1'b1; e.cycles = 4; e.mw = 8'h08; end
      6'h04: begin
        e.alu = 4'b0110; e.cycles = 3;
        if (z) e.pc = npc + {{14{w[15]}}, w[15:0], 2'b00};
      end
      6'h02: begin e.cycles = 2; e.pc = {npc[31:28], w[25:0], 2'b00}; e.ca = 1'b0; end
      6'h3F: begin e.cycles = 2; e.halt = 1'b1; e.pc = pc; e.cs = 1'b0; e.ca = 1'b0; end
      default: begin e.cycles = 2; e.ill = 1'b1; e.cs = 1'b0; e.ca = 1'b0; end
    endcase
    return e;
  endfunction

  // Drive one instruction (after optional imem stall) until it retires.
  task automatic run(input logic [31:0] w, input logic z, input logic o, input int stall,
                     output res_t r, output logic side_ok);
    logic [31:0] cnt0, pc0;
    logic [25:0] ir0;
    int          c;
    r = mk(0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 4'h0, '0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    side_ok = 1'b1;
    imem_data = w; zero = z; overflow = o;
    pc0 = imem_addr;
    ir0 = Instruction;
    for (int s = 0; s < stall; s++) begin
      imem_ready = 1'b0;
      #1;
      if (imem_addr !== pc0 || Instruction !== ir0 || MemRead || MemWrite || RegWrite)
        side_ok = 1'b0;
      tick;
    end
    if (imem_addr !== pc0 || Instruction !== ir0) side_ok = 1'b0;
    imem_ready = 1'b1;
    cnt0 = retired_cnt;
    c = 0;
    while (retired_cnt === cnt0 && c < 12) begin
      #1;
      if (c < 8) begin
        r.mr[c] = MemRead; r.mw[c] = MemWrite; r.rw[c] = RegWrite;
      end
      if (c == 1) begin
        r.rd = RegDst; r.as = ALUSrc; r.mt = MemToReg; r.alu = ALUControl_Signal;
      end
      if (c >= 1 && (ovf_trap || illegal)) side_ok = 1'b0;
      tick;
      c++;
    end
    if (retired_cnt === cnt0) begin
      total++; bad++;
      $display("FAIL retire_timeout: got no retire in %0d cycles want retire", c);
    end
    r.cycles = c; r.pc = imem_addr; r.trap = ovf_trap; r.ill = illegal; r.halt = halted;
  endtask

  task automatic cmp(input string tag, input res_t a, input res_t e);
    chk({tag, ".cycles"}, 32'(a.cycles), 32'(e.cycles));
    chk({tag, ".memread"}, {24'd0, a.mr}, {24'd0, e.mr});
    chk({tag, ".memwrite"}, {24'd0, a.mw}, {24'd0, e.mw});
    chk({tag, ".regwrite"}, {24'd0, a.rw}, {24'd0, e.rw});
    chk({tag, ".pc"}, a.pc, e.pc);
    chk({tag, ".flags"}, {29'd0, a.trap, a.ill, a.halt}, {29'd0, e.trap, e.ill, e.halt});
    if (e.cs) chk({tag, ".static"}, {29'd0, a.rd, a.as, a.mt}, {29'd0, e.rd, e.as, e.mt});
    if (e.ca) chk({tag, ".alu"}, {28'd0, a.alu}, {28'd0, e.alu});
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    logic [5:0]  fns[6];
    fns[0] = 6'h20; fns[1] = 6'h22; fns[2] = 6'h24;
    fns[3] = 6'h25; fns[4] = 6'h2A; fns[5] = 6'($urandom);
    w = $urandom;
    case ($urandom_range(0, 9))
      0, 1, 2: begin w[31:26] = 6'h00; w[5:0] = fns[$urandom_range(0, 5)]; end
      3: w[31:26] = 6'h08;
      4: w[31:26] = 6'h23;
      5: w[31:26] = 6'h2B;
      6: w[31:26] = 6'h04;
      7: w[31:26] = 6'h02;
      8: if (w[31:26] == 6'h3F) w[31:26] = 6'h3E;
      default: w[31:26] = 6'h00;
    endcase
    return w;
  endfunction

  initial begin
    res_t        r, e;
    logic        ok;
    logic [31:0] mpc, mcnt, w;
    logic        z, o;

    // Reset state
    do_reset;
    #1;
    chk("rst.pc", imem_addr, 32'h0);
    chk("rst.cnt", retired_cnt, 32'h0);
    chk("rst.ir", {6'd0, Instruction}, 32'h0);
    chk("rst.pulses", {29'd0, ovf_trap, illegal, halted}, 32'h0);
    chk("rst.we", {29'd0, MemRead, MemWrite, RegWrite}, 32'h0);

    // Directed table, executed back to back from PC 0
    add_vec(32'h00221820, 0, 0, mk(4, 8'h00, 8'h00, 8'h08, 1, 0, 1, 4'b0010, 32'h04, 0, 0, 0, 1, 1));
    add_vec(32'h8C220008, 0, 0, mk(5, 8'h18, 8'h00, 8'h10, 0, 1, 0, 4'b0010, 32'h08, 0, 0, 0, 1, 1));
    add_vec(32'hAC220004, 0, 0, mk(4, 8'h00, 8'h08, 8'h00, 0, 1, 1, 4'b0010, 32'h0C, 0, 0, 0, 1, 1));
    add_vec(32'h20217FFF, 0, 1, mk(3, 8'h00, 8'h00, 8'h00, 0, 1, 1, 4'b0010, 32'h10, 1, 0, 0, 1, 1));
    add_vec(32'h1022FFFF, 1, 0, mk(3, 8'h00, 8'h00, 8'h00, 0, 0, 1, 4'b0110, 32'h10, 0, 0, 0, 1, 1));
    add_vec(32'h1022FFFF, 0, 0, mk(3, 8'h00, 8'h00, 8'h00, 0, 0, 1, 4'b0110, 32'h14, 0, 0, 0, 1, 1));
    add_vec(32'h00221822, 0, 1, mk(3, 8'h00, 8'h00, 8'h00, 1, 0, 1, 4'b0110, 32'h18, 1, 0, 0, 1, 1));
    add_vec(32'h0022182A, 0, 1, mk(4, 8'h00, 8'h00, 8'h08, 1, 0, 1, 4'b0111, 32'h1C, 0, 0, 0, 1, 1));
    add_vec(32'h00221824, 0, 0, mk(4, 8'h00, 8'h00, 8'h08, 1, 0, 1, 4'b0000, 32'h20, 0, 0, 0, 1, 1));
    add_vec(32'h00221825, 0, 0, mk(4, 8'h00, 8'h00, 8'h08, 1, 0, 1, 4'b0001, 32'h24, 0, 0, 0, 1, 1));
    add_vec(32'h20210005, 0, 0, mk(4, 8'h00, 8'h00, 8'h08, 0, 1, 1, 4'b0010, 32'h28, 0, 0, 0, 1, 1));
    add_vec(32'h00221821, 0, 0, mk(2, 8'h00, 8'h00, 8'h00, 0, 0, 0, 4'b0000, 32'h2C, 0, 1, 0, 0, 0));
    add_vec(32'h18000000, 0, 0, mk(2, 8'h00, 8'h00, 8'h00, 0, 0, 0, 4'b0000, 32'h30, 0, 1, 0, 0, 0));
    add_vec(32'h08000040, 0, 0, mk(2, 8'h00, 8'h00, 8'h00, 0, 0, 1, 4'b0000, 32'h100, 0, 0, 0, 1, 0));
    add_vec(32'hFC000000, 0, 0, mk(2, 8'h00, 8'h00, 8'h00, 0, 0, 0, 4'b0000, 32'h100, 0, 0, 1, 0, 0));
    foreach (tv[i]) begin
      run(tv[i].word, tv[i].z, tv[i].o, 0, r, ok);
      cmp($sformatf("vec%0d", i), r, tv[i].exp);
      chk($sformatf("vec%0d.side", i), {31'd0, ok}, 32'd1);
      chk($sformatf("vec%0d.cnt", i), retired_cnt, 32'(i + 1));
    end

    // HALT is absorbing: PC frozen, enables quiet, counter steady
    for (int k = 0; k < 4; k++) begin
      imem_ready = 1'b1;
      imem_data = $urandom;
      #1;
      chk("halt.level", {31'd0, halted}, 32'd1);
      chk("halt.pc", imem_addr, 32'h100);
      chk("halt.we", {29'd0, MemRead, MemWrite, RegWrite}, 32'h0);
      tick;
    end
    chk("halt.cnt", retired_cnt, 32'd15);

    // Reset out of HALT clears everything
    do_reset;
    #1;
    chk("rst2.state", {29'd0, ovf_trap, illegal, halted}, 32'h0);
    chk("rst2.pc", imem_addr, 32'h0);
    chk("rst2.cnt", retired_cnt, 32'h0);
    chk("rst2.ir", {6'd0, Instruction}, 32'h0);

    // imem_ready low for 3 cycles: FETCH holds, PC/IR untouched
    run(32'h00221820, 0, 0, 3, r, ok);
    chk("stall.side", {31'd0, ok}, 32'd1);
    chk("stall.cycles", 32'(r.cycles), 32'd4);
    chk("stall.pc", r.pc, 32'h4);
    chk("stall.ir", {6'd0, Instruction}, 32'h00221820 & 32'h03FF_FFFF);

    // Reset asserted during sw MEM cycle
    do_reset;
    imem_data = 32'hAC220004; imem_ready = 1'b1;
    tick; tick; tick;
    #1;
    chk("swrst.mem_we_before", {31'd0, MemWrite}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("swrst.we_in_reset", {29'd0, MemRead, MemWrite, RegWrite}, 32'h0);
    tick;
    chk("swrst.pc", imem_addr, 32'h0);
    chk("swrst.cnt", retired_cnt, 32'h0);
    rst_n = 1'b1;

    // j then halt from reset
    do_reset;
    run(32'h08000040, 0, 0, 0, r, ok);
    chk("jh.j_pc", r.pc, 32'h100);
    run(32'hFC000000, 0, 0, 0, r, ok);
    chk("jh.halted", {31'd0, r.halt}, 32'd1);
    chk("jh.pc", r.pc, 32'h100);
    chk("jh.cnt", retired_cnt, 32'd2);
    tick; tick;
    chk("jh.stays", {31'd0, halted}, 32'd1);

    // Random instruction stream against the model
    do_reset;
    mpc = 32'h0;
    mcnt = 32'h0;
    for (int n = 0; n < 250; n++) begin
      w = rand_word();
      z = 1'($urandom);
      o = 1'($urandom);
      e = model(w, mpc, z, o);
      run(w, z, o, $urandom_range(0, 2), r, ok);
      cmp($sformatf("rnd%0d[%h]", n, w), r, e);
      chk($sformatf("rnd%0d.side", n), {31'd0, ok}, 32'd1);
      mpc = e.pc;
      mcnt = mcnt + 32'd1;
      chk($sformatf("rnd%0d.cnt", n), retired_cnt, mcnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
